// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. It holds a committed display word of 4-bit digit codes and steps
// through the anodes one slot at a time. Each slot starts with a short dead
// time with all anodes off. New data is staged in a pending register and is
// only copied into the display at a frame boundary. The controller also
// provides leading-zero blanking and a blinking "FAIL" message mode.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_enable       1 = scanning; 0 = display dark, counters frozen
//   i_load         single-cycle strobe, captures i_data_in / i_dp_in as pending
//   i_data_in      digit codes, [4k+3:4k] = digit k (digit 0 = rightmost)
//   i_dp_in        decimal point per digit, 1 = lit
//   i_blank_lz     1 = suppress leading zeros
//   i_fail         level, 1 = show blinking "FAIL"
//   o_bcd          digit code to the downstream segment decoder, 4'hF = blank
//   o_an           anodes, active low
//   o_dp           decimal-point cathode, active low
//   o_upd_ack      one-cycle pulse after pending data is committed
//   o_frame_done   one-cycle pulse on the last cycle of each full frame
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYC     = 16,
    parameter int BLINK_FRAMES = 62
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_data_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_blank_lz,
    input  logic                    i_fail,
    output logic [3:0]              o_bcd,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_dp,
    output logic                    o_upd_ack,
    output logic                    o_frame_done
);

    localparam int PW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_LEN     = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_vld;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_blink_on;
    logic                    r_commit;
    logic [3:0]              r_bcd;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_dp;
    logic                    r_upd_ack;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_commit;
    logic                    w_dead;
    logic                    w_dark;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_lz_run;
    logic [3:0]              w_digit;
    logic                    w_dp_bit;
    logic                    w_lz_bit;
    logic [3:0]              w_fail_code;
    logic [3:0]              w_bcd_nxt;
    logic                    w_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    assign w_slot_end  = i_enable && (r_presc == PRESC_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_commit    = w_frame_end && r_pend_vld;
    assign w_dead      = (r_presc < DEAD_LEN);
    // Blink off phase darkens every anode, not just the message digits.
    assign w_dark      = w_dead || (i_fail && !r_blink_on);

    // Leading-zero mask: walk down from the most significant digit while
    // codes are zero. Digit 0 is never part of the mask.
    always_comb begin
        w_lz_mask = '0;
        w_lz_run  = i_blank_lz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_lz_run     = w_lz_run && (r_disp[4*k +: 4] == 4'h0);
            w_lz_mask[k] = w_lz_run;
        end
    end

    always_comb begin
        w_digit  = 4'h0;
        w_dp_bit = 1'b0;
        w_lz_bit = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit  = r_disp[4*k +: 4];
                w_dp_bit = r_disp_dp[k];
                w_lz_bit = w_lz_mask[k];
            end
        end
    end

    // Codes B..E are the decoder glyphs for F, A, I, L.
    always_comb begin
        w_fail_code = 4'hF;
        if (r_idx == IW'(0))      w_fail_code = 4'hE;
        else if (r_idx == IW'(1)) w_fail_code = 4'hD;
        else if (r_idx == IW'(2)) w_fail_code = 4'hC;
        else if (r_idx == IW'(3)) w_fail_code = 4'hB;
    end

    always_comb begin
        w_bcd_nxt = w_digit;
        w_dp_nxt  = ~w_dp_bit;
        if (i_fail) begin
            w_bcd_nxt = r_blink_on ? w_fail_code : 4'hF;
            w_dp_nxt  = 1'b1;
        end else if (w_lz_bit) begin
            w_bcd_nxt = 4'hF;
            w_dp_nxt  = 1'b1;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_an_nxt[k] = w_dark || (r_idx != IW'(k));
        end
    end

    // Slot position and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (i_enable) begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Pending capture runs even while disabled. A load that coincides with
    // a commit still wins, so the new data waits for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
            r_disp     <= '0;
            r_disp_dp  <= '0;
            r_commit   <= 1'b0;
        end else begin
            if (i_load) begin
                r_pend     <= i_data_in;
                r_pend_dp  <= i_dp_in;
                r_pend_vld <= 1'b1;
            end else if (w_commit) begin
                r_pend_vld <= 1'b0;
            end
            if (w_commit) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
            r_commit <= w_commit;
        end
    end

    // Blink phase: down-counter of frame ends while in fail mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= BLINK_RELOAD;
            r_blink_on  <= 1'b1;
        end else if (!i_fail) begin
            r_blink_cnt <= BLINK_RELOAD;
            r_blink_on  <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == '0) begin
                r_blink_cnt <= BLINK_RELOAD;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt - 1'b1;
            end
        end
    end

    // Outputs are registered. frame_done therefore lines up with the last
    // registered cycle of the final slot, and upd_ack trails it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd        <= 4'hF;
            r_an         <= '1;
            r_dp         <= 1'b1;
            r_upd_ack    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (i_enable) begin
                r_bcd <= w_bcd_nxt;
                r_an  <= w_an_nxt;
                r_dp  <= w_dp_nxt;
            end else begin
                r_bcd <= 4'hF;
                r_an  <= '1;
                r_dp  <= 1'b1;
            end
            r_frame_done <= w_frame_end;
            r_upd_ack    <= r_commit;
        end
    end

    assign o_bcd        = r_bcd;
    assign o_an         = r_an;
    assign o_dp         = r_dp;
    assign o_upd_ack    = r_upd_ack;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_controller.sv
module tb_ssd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        fail = 1'b0;
    logic [3:0]  bcd;
    logic [7:0]  an;
    logic        dp;
    logic        upd_ack;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    logic [3:0] cap_bcd [32];
    logic [7:0] cap_an  [32];
    logic       cap_dp  [32];
    logic       cap_fd  [32];
    logic       cap_ack [32];

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .NUM_DIGITS(8), .REFRESH_DIV(4), .DEAD_CYC(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_load(load),
        .i_data_in(data_in), .i_dp_in(dp_in), .i_blank_lz(blank_lz),
        .i_fail(fail), .o_bcd(bcd), .o_an(an), .o_dp(dp),
        .o_upd_ack(upd_ack), .o_frame_done(frame_done)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [7:0] scan_an(input int c);
        logic [7:0] one;
        one = 8'h01;
        return ((c % 4) == 0) ? 8'hFF : ~(one << (c / 4));
    endfunction

    function automatic logic [3:0] msg_code(input int k);
        case (k)
            0: return 4'hE;
            1: return 4'hD;
            2: return 4'hC;
            3: return 4'hB;
            default: return 4'hF;
        endcase
    endfunction

    task automatic sync_fd(output int n, output int acks);
        n = 0;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (upd_ack === 1'b1) acks++;
            if (frame_done === 1'b1) break;
        end
    endtask

    task automatic grab();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            cap_bcd[c] = bcd;
            cap_an[c]  = an;
            cap_dp[c]  = dp;
            cap_fd[c]  = frame_done;
            cap_ack[c] = upd_ack;
        end
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        fork
            begin
                @(negedge clk);
                load = 1'b0;
            end
        join_none
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an got %h exp ff", an); end
        total++; if (bcd !== 4'hF) begin bad++; $display("FAIL reset_bcd got %h exp f", bcd); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got %b exp 1", dp); end
        total++; if (upd_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b exp 0", upd_ack); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    endtask

    task automatic test_basic();
        int n, acks;
        logic [31:0] w;
        w = 32'h12345678;
        @(negedge clk);
        rst_n = 1'b1;
        data_in = w; dp_in = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sync_fd(n, acks);
        total++; if (n != 31) begin bad++; $display("FAIL basic_first_fd got %0d exp 31", n); end
        total++; if (acks != 0) begin bad++; $display("FAIL basic_early_ack got %0d exp 0", acks); end
        for (int f = 0; f < 2; f++) begin
            grab();
            for (int c = 0; c < 32; c++) begin
                total++; if (cap_bcd[c] !== w[4*(c/4) +: 4]) begin bad++;
                    $display("FAIL basic_bcd f=%0d c=%0d got %h exp %h", f, c, cap_bcd[c], w[4*(c/4) +: 4]); end
                total++; if (cap_an[c] !== scan_an(c)) begin bad++;
                    $display("FAIL basic_an f=%0d c=%0d got %h exp %h", f, c, cap_an[c], scan_an(c)); end
                total++; if (cap_dp[c] !== 1'b1) begin bad++;
                    $display("FAIL basic_dp f=%0d c=%0d got %b exp 1", f, c, cap_dp[c]); end
                total++; if (cap_fd[c] !== (c == 31)) begin bad++;
                    $display("FAIL basic_fd f=%0d c=%0d got %b exp %b", f, c, cap_fd[c], c == 31); end
                total++; if (cap_ack[c] !== (f == 0 && c == 0)) begin bad++;
                    $display("FAIL basic_ack f=%0d c=%0d got %b exp %b", f, c, cap_ack[c], f == 0 && c == 0); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, acks;
        @(negedge clk);
        data_in = 32'h11111111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        data_in = 32'h22222222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sync_fd(n, acks);
        total++; if (n != 24) begin bad++; $display("FAIL b2b_fd_pos got %0d exp 24", n); end
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_ack[c] !== (c == 0)) begin bad++;
                $display("FAIL b2b_ack c=%0d got %b exp %b", c, cap_ack[c], c == 0); end
            total++; if (cap_bcd[c] !== 4'h2) begin bad++;
                $display("FAIL b2b_bcd c=%0d got %h exp 2", c, cap_bcd[c]); end
        end
        // Load on the frame_done cycle: no commit at the end of the next frame's start
        pulse_load(32'h33333333, 8'h00);
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_ack[c] !== 1'b0) begin bad++;
                $display("FAIL fdload_ack_early c=%0d got %b exp 0", c, cap_ack[c]); end
            total++; if (cap_bcd[c] !== 4'h2) begin bad++;
                $display("FAIL fdload_bcd_old c=%0d got %h exp 2", c, cap_bcd[c]); end
        end
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_ack[c] !== (c == 0)) begin bad++;
                $display("FAIL fdload_ack c=%0d got %b exp %b", c, cap_ack[c], c == 0); end
            total++; if (cap_bcd[c] !== 4'h3) begin bad++;
                $display("FAIL fdload_bcd_new c=%0d got %h exp 3", c, cap_bcd[c]); end
        end
    endtask

    task automatic test_leading_zero();
        int n, acks;
        logic [3:0] exp_b [8];
        logic       exp_d [8];
        exp_b = '{4'h5, 4'h0, 4'hA, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        blank_lz = 1'b1;
        pulse_load(32'h00000A05, 8'hFF);
        sync_fd(n, acks);
        total++; if (n != 32) begin bad++; $display("FAIL lz_sync got %0d exp 32", n); end
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_bcd[c] !== exp_b[c/4]) begin bad++;
                $display("FAIL lz_bcd c=%0d got %h exp %h", c, cap_bcd[c], exp_b[c/4]); end
            total++; if (cap_dp[c] !== exp_d[c/4]) begin bad++;
                $display("FAIL lz_dp c=%0d got %b exp %b", c, cap_dp[c], exp_d[c/4]); end
        end
        pulse_load(32'h00000000, 8'hFF);
        sync_fd(n, acks);
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_bcd[c] !== ((c < 4) ? 4'h0 : 4'hF)) begin bad++;
                $display("FAIL lz0_bcd c=%0d got %h exp %h", c, cap_bcd[c], (c < 4) ? 4'h0 : 4'hF); end
            total++; if (cap_dp[c] !== (c >= 4)) begin bad++;
                $display("FAIL lz0_dp c=%0d got %b exp %b", c, cap_dp[c], c >= 4); end
        end
    endtask

    task automatic test_fail_mode();
        int n, acks;
        logic on;
        logic [31:0] w;
        logic [3:0] eb;
        logic [7:0] ea;
        w = 32'h12345678;
        blank_lz = 1'b0;
        pulse_load(w, 8'h00);
        sync_fd(n, acks);
        fail = 1'b1;
        for (int f = 0; f < 5; f++) begin
            grab();
            on = (f == 0) || (f == 1) || (f == 4);
            for (int c = 0; c < 32; c++) begin
                eb = on ? msg_code(c / 4) : 4'hF;
                ea = on ? scan_an(c) : 8'hFF;
                total++; if (cap_bcd[c] !== eb) begin bad++;
                    $display("FAIL msg_bcd f=%0d c=%0d got %h exp %h", f, c, cap_bcd[c], eb); end
                total++; if (cap_an[c] !== ea) begin bad++;
                    $display("FAIL msg_an f=%0d c=%0d got %h exp %h", f, c, cap_an[c], ea); end
                total++; if (cap_dp[c] !== 1'b1) begin bad++;
                    $display("FAIL msg_dp f=%0d c=%0d got %b exp 1", f, c, cap_dp[c]); end
            end
        end
        fail = 1'b0;
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_bcd[c] !== w[4*(c/4) +: 4]) begin bad++;
                $display("FAIL msg_exit_bcd c=%0d got %h exp %h", c, cap_bcd[c], w[4*(c/4) +: 4]); end
            total++; if (cap_an[c] !== scan_an(c)) begin bad++;
                $display("FAIL msg_exit_an c=%0d got %h exp %h", c, cap_an[c], scan_an(c)); end
        end
        // Blink phase restarts fresh after fail dropped: on, on, off
        fail = 1'b1;
        for (int f = 0; f < 3; f++) begin
            grab();
            on = (f < 2);
            for (int c = 0; c < 32; c++) begin
                eb = on ? msg_code(c / 4) : 4'hF;
                total++; if (cap_bcd[c] !== eb) begin bad++;
                    $display("FAIL msg_rearm_bcd f=%0d c=%0d got %h exp %h", f, c, cap_bcd[c], eb); end
            end
        end
        fail = 1'b0;
    endtask

    task automatic test_enable_pause();
        int fd_at;
        fd_at = -1;
        for (int j = 1; j <= 6; j++) @(negedge clk);
        total++; if (an !== 8'hFD || bcd !== 4'h7) begin bad++;
            $display("FAIL pause_pre got an=%h bcd=%h exp an=fd bcd=7", an, bcd); end
        enable = 1'b0;
        for (int j = 7; j <= 16; j++) begin
            @(negedge clk);
            total++; if (an !== 8'hFF || bcd !== 4'hF || dp !== 1'b1) begin bad++;
                $display("FAIL pause_dark j=%0d got an=%h bcd=%h dp=%b exp ff f 1", j, an, bcd, dp); end
        end
        enable = 1'b1;
        @(negedge clk);
        total++; if (an !== 8'hFD || bcd !== 4'h7) begin bad++;
            $display("FAIL pause_resume got an=%h bcd=%h exp an=fd bcd=7", an, bcd); end
        for (int j = 18; j <= 80; j++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_at = j;
                break;
            end
        end
        total++; if (fd_at != 42) begin bad++; $display("FAIL pause_fd_delay got %0d exp 42", fd_at); end
    endtask

    task automatic test_reset_midframe();
        int n, acks;
        pulse_load(32'h87654321, 8'h00);
        for (int j = 1; j <= 6; j++) @(negedge clk);
        total++; if (an !== 8'hFD) begin bad++; $display("FAIL rst_pre_an got %h exp fd", an); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (an !== 8'hFF || bcd !== 4'hF || dp !== 1'b1) begin bad++;
            $display("FAIL rst_async got an=%h bcd=%h dp=%b exp ff f 1", an, bcd, dp); end
        total++; if (upd_ack !== 1'b0 || frame_done !== 1'b0) begin bad++;
            $display("FAIL rst_async_pulses got ack=%b fd=%b exp 0 0", upd_ack, frame_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync_fd(n, acks);
        total++; if (n != 32) begin bad++; $display("FAIL rst_fd got %0d exp 32", n); end
        total++; if (acks != 0) begin bad++; $display("FAIL rst_ack_early got %0d exp 0", acks); end
        grab();
        for (int c = 0; c < 32; c++) begin
            total++; if (cap_ack[c] !== 1'b0) begin bad++;
                $display("FAIL rst_lost_ack c=%0d got %b exp 0", c, cap_ack[c]); end
            total++; if (cap_bcd[c] !== 4'h0) begin bad++;
                $display("FAIL rst_bcd c=%0d got %h exp 0", c, cap_bcd[c]); end
            total++; if (cap_an[c] !== scan_an(c)) begin bad++;
                $display("FAIL rst_an c=%0d got %h exp %h", c, cap_an[c], scan_an(c)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_leading_zero();
        test_fail_mode();
        test_enable_pause();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display on the Nexys4 DDR.
- Holds a 32-bit display word of eight 4-bit digit codes and rotates through the anodes at a fixed refresh rate.
- Presents one digit code per slot to the existing combinational 4-bit-to-segment decoder, which sits downstream.
- Adds frame-synchronous update, leading-zero blanking, anti-ghost dead time, and a blinking "FAIL" message mode.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (index 0 = rightmost).
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per slot at 100 MHz).
- DEAD_CYC, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLINK_FRAMES, 62, full frames per blink half-period in fail mode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scanning; 0 = display dark, counters frozen.
- load  in  1  single-cycle strobe; captures data_in and dp_in into the pending register.
- data_in  in  32  digit codes; [4k+3:4k] = digit k.
- dp_in  in  8  decimal point per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- fail  in  1  level; 1 = show blinking "FAIL".
- bcd  out  4  digit code to the segment decoder; 4'hF = blank.
- an  out  8  anodes, active low.
- dp  out  1  decimal-point cathode, active low.
- upd_ack  out  1  one-cycle pulse when pending data is committed to the display.
- frame_done  out  1  one-cycle pulse at the end of each full 8-digit frame.

Behaviour:
- Reset (async assert, sync release): an=8'hFF, bcd=4'hF, dp=1, upd_ack=0, frame_done=0. Display and pending registers = 0, pending flag = 0, prescaler = 0, digit index = 0, blink phase = on.
- Outputs are registered. Each slot is exactly REFRESH_DIV cycles.
- Dead time: for the first DEAD_CYC cycles of a slot, an=8'hFF and bcd/dp already show the new digit. After that, an has only bit [index] low.
- Digit index increments 0..NUM_DIGITS-1 and wraps to 0. frame_done pulses on the last cycle of the slot for index NUM_DIGITS-1.
- Load handling:
  - load sets the pending flag and captures data_in/dp_in.
  - A second load before commit overwrites the pending data; the last value wins.
  - Commit happens on the frame_done cycle: display <= pending, flag cleared, upd_ack=1 in the next cycle.
  - A load in the same cycle as frame_done is captured but not committed until the next frame.
- Leading-zero blanking (blank_lz=1):
  - Starting from digit 7 downward, each digit with code 4'h0 is replaced by 4'hF until the first nonzero code.
  - Digit 0 is never blanked.
  - 4'hA counts as nonzero, so it is displayed.
  - Evaluation uses the committed display register, combinationally per slot.
- Decimal point: dp = ~dp_reg[index], forced to 1 if the digit is blanked by leading-zero suppression or in fail mode.
- Fail mode (fail=1) overrides the display register; the register still accepts loads and commits:
  - digit 3 = 4'hB, digit 2 = 4'hC, digit 1 = 4'hD, digit 0 = 4'hE, digits 7..4 = 4'hF.
  - The blink phase toggles every BLINK_FRAMES frame_done pulses. In the off phase all bcd = 4'hF and an=8'hFF.
  - The blink counter resets to phase = on when fail falls.
- Codes 4'h1..4'h9 and 4'hB..4'hE from the display register pass through unchanged.
- enable=0:
  - Next cycle an=8'hFF, bcd=4'hF, dp=1.
  - Prescaler, index and blink counter hold; load/commit stay frozen except pending capture.
  - On re-enable, scanning resumes in the held slot from the held prescaler value.
- Reset mid-frame: all state returns to reset values immediately; pending data is lost.

Test Plan (REFRESH_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2):
- Reset release, enable=1, load data_in=32'h12345678, dp_in=8'h00:
  - upd_ack after the first frame_done.
  - Next frame: slot k shows bcd = digit k (8,7,...,1).
  - an = ~(1<<k) on cycles 1..3 of each slot, 8'hFF on cycle 0.
  - frame_done every 32 cycles.
- Two loads (32'h11111111 then 32'h22222222) within one frame: a single upd_ack; the display shows all 2s. A load on a frame_done cycle commits one frame later.
- blank_lz=1 with data 32'h00000A05: digits 7..3 show bcd=F with dp=1, digit 2 shows A, digit 1 shows 0, digit 0 shows 5. With data 0, only digit 0 shows 0.
- fail=1:
  - digits 3..0 show B,C,D,E and 7..4 show F for 2 frames, then all dark for 2 frames, repeating.
  - After fail falls, the committed data reappears at the next slot.
- enable=0 mid-slot for 10 cycles: an=FF, bcd=F. On re-enable the same index resumes with the remaining prescaler count; frame_done is delayed by exactly 10 cycles.
- Assert rst_n=0 mid-frame with pending load: an=FF and bcd=F asynchronously. After release the display is 0 and no upd_ack is produced for the lost load.
